ube_dma_seq: RTL
================

Name: ube_dma_seq

Overview:
- DMA sequencer for the Unibus Exerciser (UBE).
- Drives the UBE buffer address register's increment strobe and runs a word-counted burst of Unibus transfers.
- For each word it requests the bus, waits for acknowledge or timeout, then advances the buffer address by one word (+4 bytes).
- Sits between the UBE CSR/word-count registers and the device bus request/acknowledge interface.

Parameters:
- TIMEOUT, 63, cycles to wait for busACK before flagging non-existent memory (NXM); 6-bit counter.
- WCW, 16, width of the word count register.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- devRESET  in  1  Unibus INIT; same effect as rst
- wcWRITE  in  1  load word count from devDATAI[WCW-1:0]
- devDATAI  in  36  device write data
- goWRITE  in  1  start command; sampled only in IDLE
- dirWRITE  in  1  transfer direction latched at start (1 = UBE writes memory)
- busACK  in  1  bus transfer acknowledge, one-cycle pulse
- busREQ  out  1  bus transfer request
- busWRITE  out  1  direction of the current request
- ubeINC  out  1  one-cycle pulse to the buffer address register (+4)
- regWC  out  WCW  remaining word count
- busy  out  1  sequence in progress
- done  out  1  sticky completion flag
- nxm  out  1  sticky timeout error
- intr  out  1  interrupt request (optional feature only)

Behaviour:
- Reset (rst or devRESET, synchronous, highest priority) forces:
  - state IDLE
  - regWC=0, busREQ=0, busWRITE=0, ubeINC=0, busy=0, done=0, nxm=0, intr=0, timer=0
  - A reset mid-operation abandons the transfer immediately; no ubeINC is issued.
- States: IDLE, REQ, WAIT, INC, FIN.
- IDLE:
  - wcWRITE loads regWC.
  - goWRITE latches dirWRITE into busWRITE, clears done and nxm, and sets busy.
  - Next state: REQ if regWC!=0, else FIN (zero count gives no transfers and done one cycle later).
  - wcWRITE and goWRITE in the same cycle: the load takes effect first, and the new value decides REQ/FIN.
- REQ:
  - Assert busREQ (registered, high from the next cycle), clear the timer, go to WAIT.
- WAIT:
  - busREQ held high; timer increments each cycle.
  - busACK: drop busREQ, go to INC.
  - Timer reaches TIMEOUT with no busACK: drop busREQ, set nxm, go to FIN. No ubeINC and no count decrement on timeout.
  - busACK in the same cycle as the timeout: the ack wins.
- INC:
  - ubeINC high for exactly one cycle; regWC decrements by 1.
  - Next state: REQ if the new regWC!=0, else FIN.
  - Latency: one word takes 3 cycles plus the ack wait.
- FIN:
  - Set done, clear busy, return to IDLE (one cycle).
- busy is high from the cycle after goWRITE through FIN.
- wcWRITE and goWRITE outside IDLE are ignored.
- busACK outside WAIT is ignored.
- regWC wraps never: decrement happens only when nonzero. Arithmetic is unsigned, modulo 2^WCW.
- The address register's ubeINC path has lower priority than a CSR address write. This block does not gate it.

Optional Feature:
- Macro UBE_DMA_SEQ_INTR_EN.
- Defined: intr sets together with done or nxm and stays high until the next goWRITE or reset.
- Undefined: intr is tied to 0 and no interrupt logic is synthesized.

Test Plan:
- Reset then wcWRITE data=3, goWRITE, busACK 2 cycles after each busREQ -> three busREQ pulses, three single-cycle ubeINC, regWC 3→2→1→0, done=1, busy=0, nxm=0.
- wcWRITE 0, goWRITE -> no busREQ, no ubeINC, done=1 two cycles after goWRITE.
- wcWRITE 2, goWRITE, never ack -> busREQ held 63 cycles then dropped, nxm=1, done=1, regWC=2, zero ubeINC.
- wcWRITE 5, goWRITE, assert rst during the 2nd WAIT -> next cycle all outputs 0, state IDLE, no further ubeINC.
- busACK coincident with the timeout cycle, WC=1 -> ubeINC pulses, nxm=0, done=1. A second goWRITE during busy is ignored (exactly 1 transfer).
- With UBE_DMA_SEQ_INTR_EN: WC=1 completes -> intr=1 after done; goWRITE clears it. Without the macro, intr stays 0 throughout.

Source files
------------

// File: rtl/ube_dma_seq_if.sv
// Handshake and CSR strobe bundle between the UBE CSR/bus side and the DMA sequencer.
interface ube_dma_seq_if #(
    parameter int unsigned WCW = 16
);
    logic           devRESET;
    logic           wcWRITE;
    logic [35:0]    devDATAI;
    logic           goWRITE;
    logic           dirWRITE;
    logic           busACK;
    logic           busREQ;
    logic           busWRITE;
    logic           ubeINC;
    logic [WCW-1:0] regWC;
    logic           busy;
    logic           done;
    logic           nxm;
    logic           intr;

    modport master (
        output devRESET, wcWRITE, devDATAI, goWRITE, dirWRITE, busACK,
        input  busREQ, busWRITE, ubeINC, regWC, busy, done, nxm, intr
    );

    modport slave (
        input  devRESET, wcWRITE, devDATAI, goWRITE, dirWRITE, busACK,
        output busREQ, busWRITE, ubeINC, regWC, busy, done, nxm, intr
    );
endinterface

// File: rtl/ube_dma_seq.sv
// UBE DMA sequencer: word-counted burst of bus requests with ack timeout (NXM) detection.
// Optional interrupt output enabled by defining UBE_DMA_SEQ_INTR_EN.
module ube_dma_seq #(
    parameter int unsigned TIMEOUT = 63,
    parameter int unsigned WCW     = 16
) (
    input logic          clk,
    input logic          rst,
    ube_dma_seq_if.slave bus
);
    typedef enum logic [2:0] {StIdle, StReq, StWait, StInc, StFin} state_e;

    // Last WAIT cycle index before the request is abandoned.
    localparam logic [5:0] TimerLast = 6'(TIMEOUT - 1);

    state_e         r_state, w_state_next;
    logic [WCW-1:0] r_wc, w_wc_next, w_wc_load;
    logic [5:0]     r_timer, w_timer_next;
    logic           r_req, w_req_next;
    logic           r_write, w_write_next;
    logic           r_busy, w_busy_next;
    logic           r_done, w_done_next;
    logic           r_nxm, w_nxm_next;
    logic           w_rst;
    logic           w_timeout;
    logic           w_unused_data;

    assign w_rst         = rst | bus.devRESET;
    assign w_wc_load     = bus.wcWRITE ? bus.devDATAI[WCW-1:0] : r_wc;
    assign w_timeout     = (r_state == StWait) && !bus.busACK && (r_timer == TimerLast);
    assign w_unused_data = ^bus.devDATAI[35:WCW];

    always_comb begin
        w_state_next = r_state;
        w_wc_next    = r_wc;
        w_timer_next = r_timer;
        w_req_next   = r_req;
        w_write_next = r_write;
        w_busy_next  = r_busy;
        w_done_next  = r_done;
        w_nxm_next   = r_nxm;
        unique case (r_state)
            StIdle: begin
                w_wc_next = w_wc_load;
                if (bus.goWRITE) begin
                    w_write_next = bus.dirWRITE;
                    w_done_next  = 1'b0;
                    w_nxm_next   = 1'b0;
                    w_busy_next  = 1'b1;
                    w_state_next = (w_wc_load != '0) ? StReq : StFin;
                end
            end
            StReq: begin
                w_req_next   = 1'b1;
                w_timer_next = '0;
                w_state_next = StWait;
            end
            StWait: begin
                // Ack takes priority over a coincident timeout.
                if (bus.busACK) begin
                    w_req_next   = 1'b0;
                    w_state_next = StInc;
                end else if (r_timer == TimerLast) begin
                    w_req_next   = 1'b0;
                    w_nxm_next   = 1'b1;
                    w_state_next = StFin;
                end else begin
                    w_timer_next = r_timer + 6'd1;
                end
            end
            StInc: begin
                if (r_wc != '0) begin
                    w_wc_next = r_wc - WCW'(1);
                end
                w_state_next = (w_wc_next != '0) ? StReq : StFin;
            end
            StFin: begin
                w_done_next  = 1'b1;
                w_busy_next  = 1'b0;
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_state <= StIdle;
            r_wc    <= '0;
            r_timer <= '0;
            r_req   <= 1'b0;
            r_write <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_nxm   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_wc    <= w_wc_next;
            r_timer <= w_timer_next;
            r_req   <= w_req_next;
            r_write <= w_write_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
            r_nxm   <= w_nxm_next;
        end
    end

    assign bus.busREQ   = r_req;
    assign bus.busWRITE = r_write;
    assign bus.ubeINC   = (r_state == StInc);
    assign bus.regWC    = r_wc;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.nxm      = r_nxm;

`ifdef UBE_DMA_SEQ_INTR_EN
    logic r_intr;

    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_intr <= 1'b0;
        end else if ((r_state == StIdle) && bus.goWRITE) begin
            r_intr <= 1'b0;
        end else if (w_timeout || (r_state == StFin)) begin
            r_intr <= 1'b1;
        end
    end

    assign bus.intr = r_intr;
`else
    assign bus.intr = 1'b0;
`endif
endmodule
